// File: rtl/pacote_riscv.sv
// Shared RV32I pipeline constants and the MEM/WB field bundle.
package pacote_riscv;

  // Result select encodings; 2'b11 falls back to the ALU result.
  localparam logic [1:0] SEL_ULA = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_PC4 = 2'b10;

  // Load funct3 encodings.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Every field of the MEM/WB register except the valid bit.
  typedef struct packed {
    logic        reg_write;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [31:0] resultado_ula;
    logic [31:0] dado_memoria;
    logic [31:0] pc_mais4;
    logic [2:0]  funct3;
    logic [1:0]  endereco_byte;
  } campos_mem_wb_t;

endpackage

// File: rtl/extensor_carga.sv
// Load data alignment and sign/zero extension; purely combinational.
module extensor_carga
  import pacote_riscv::*;
(
  input  logic [31:0] palavra,
  input  logic [2:0]  funct3,
  input  logic [1:0]  deslocamento,
  output logic [31:0] dado_estendido
);

  logic [7:0]  byte_sel;
  logic [15:0] meia_sel;

  // Pick the addressed byte and half-word; deslocamento[0] is ignored for halves.
  always_comb begin
    byte_sel = palavra[7:0];
    unique case (deslocamento)
      2'd0: byte_sel = palavra[7:0];
      2'd1: byte_sel = palavra[15:8];
      2'd2: byte_sel = palavra[23:16];
      2'd3: byte_sel = palavra[31:24];
      default: byte_sel = palavra[7:0];
    endcase
    meia_sel = deslocamento[1] ? palavra[31:16] : palavra[15:0];
  end

  // Extend according to load type; unknown funct3 passes the whole word.
  always_comb begin
    dado_estendido = palavra;
    case (funct3)
      F3_LB:   dado_estendido = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  dado_estendido = {24'd0, byte_sel};
      F3_LH:   dado_estendido = {{16{meia_sel[15]}}, meia_sel};
      F3_LHU:  dado_estendido = {16'd0, meia_sel};
      default: dado_estendido = palavra;
    endcase
  end

endmodule

// File: rtl/estagio_wb.sv
// Write-back stage: MEM/WB register, load extension, result select and retire counter.
module estagio_wb
  import pacote_riscv::*;
#(
  parameter int unsigned LARGURA_CONTADOR = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        flush,
  input  logic                        valido_mem,
  input  logic                        reg_write_mem,
  input  logic [4:0]                  endereco_destino_mem,
  input  logic [1:0]                  sel_resultado_mem,
  input  logic [31:0]                 resultado_ula_mem,
  input  logic [31:0]                 dado_memoria_mem,
  input  logic [31:0]                 pc_mais4_mem,
  input  logic [2:0]                  funct3_mem,
  input  logic [1:0]                  endereco_byte_mem,
  output logic                        habilita_escrita,
  output logic [4:0]                  endereco_destino,
  output logic [31:0]                 dado_escrita,
  output logic                        valido_wb,
  output logic [LARGURA_CONTADOR-1:0] contador_instrucoes
);

  logic                        valido_q;
  campos_mem_wb_t              campos_d, campos_q;
  logic [LARGURA_CONTADOR-1:0] contador_q;
  logic [31:0]                 dado_carga;

  // Bundle the MEM-stage inputs into the register layout.
  always_comb begin
    campos_d               = '0;
    campos_d.reg_write     = reg_write_mem;
    campos_d.rd            = endereco_destino_mem;
    campos_d.sel           = sel_resultado_mem;
    campos_d.resultado_ula = resultado_ula_mem;
    campos_d.dado_memoria  = dado_memoria_mem;
    campos_d.pc_mais4      = pc_mais4_mem;
    campos_d.funct3        = funct3_mem;
    campos_d.endereco_byte = endereco_byte_mem;
  end

  // MEM/WB register: reset > flush > stall > capture. Flush leaves fields as they were.
  always_ff @(posedge clk) begin
    if (reset) begin
      valido_q <= 1'b0;
      campos_q <= '0;
    end else if (flush) begin
      valido_q <= 1'b0;
    end else if (!stall) begin
      valido_q <= valido_mem;
      campos_q <= campos_d;
    end
  end

  // Retire counter: one per instruction leaving WB, wraps freely.
  always_ff @(posedge clk) begin
    if (reset) begin
      contador_q <= '0;
    end else if (valido_q && !stall) begin
      contador_q <= contador_q + LARGURA_CONTADOR'(1);
    end
  end

  extensor_carga u_extensor_carga (
    .palavra        (campos_q.dado_memoria),
    .funct3         (campos_q.funct3),
    .deslocamento   (campos_q.endereco_byte),
    .dado_estendido (dado_carga)
  );

  // Result select and register-file write port; data is driven even without a write.
  always_comb begin
    dado_escrita = campos_q.resultado_ula;
    case (campos_q.sel)
      SEL_MEM: dado_escrita = dado_carga;
      SEL_PC4: dado_escrita = campos_q.pc_mais4;
      default: dado_escrita = campos_q.resultado_ula;
    endcase
    habilita_escrita = valido_q & campos_q.reg_write & (campos_q.rd != REG_ZERO);
  end

  assign endereco_destino    = campos_q.rd;
  assign valido_wb           = valido_q;
  assign contador_instrucoes = contador_q;

endmodule

// File: tb/tb_estagio_wb.sv
// Scoreboard bench for estagio_wb: stimulus pushes expected writes, a negedge monitor checks.
module tb_estagio_wb;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } esperado_t;

  logic        clk = 1'b0;
  logic        reset, stall, flush, valido_mem, reg_write_mem;
  logic [4:0]  endereco_destino_mem;
  logic [1:0]  sel_resultado_mem;
  logic [31:0] resultado_ula_mem, dado_memoria_mem, pc_mais4_mem;
  logic [2:0]  funct3_mem;
  logic [1:0]  endereco_byte_mem;

  logic        habilita_escrita, valido_wb;
  logic [4:0]  endereco_destino;
  logic [31:0] dado_escrita, contador_instrucoes;
  logic        habilita_escrita4, valido_wb4;
  logic [4:0]  endereco_destino4;
  logic [31:0] dado_escrita4;
  logic [3:0]  contador4;

  esperado_t   exp_q[$];
  int unsigned exp_cnt = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;

  estagio_wb #(.LARGURA_CONTADOR(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valido_mem(valido_mem),
    .reg_write_mem(reg_write_mem), .endereco_destino_mem(endereco_destino_mem),
    .sel_resultado_mem(sel_resultado_mem), .resultado_ula_mem(resultado_ula_mem),
    .dado_memoria_mem(dado_memoria_mem), .pc_mais4_mem(pc_mais4_mem),
    .funct3_mem(funct3_mem), .endereco_byte_mem(endereco_byte_mem),
    .habilita_escrita(habilita_escrita), .endereco_destino(endereco_destino),
    .dado_escrita(dado_escrita), .valido_wb(valido_wb),
    .contador_instrucoes(contador_instrucoes)
  );

  estagio_wb #(.LARGURA_CONTADOR(4)) dut4 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valido_mem(valido_mem),
    .reg_write_mem(reg_write_mem), .endereco_destino_mem(endereco_destino_mem),
    .sel_resultado_mem(sel_resultado_mem), .resultado_ula_mem(resultado_ula_mem),
    .dado_memoria_mem(dado_memoria_mem), .pc_mais4_mem(pc_mais4_mem),
    .funct3_mem(funct3_mem), .endereco_byte_mem(endereco_byte_mem),
    .habilita_escrita(habilita_escrita4), .endereco_destino(endereco_destino4),
    .dado_escrita(dado_escrita4), .valido_wb(valido_wb4),
    .contador_instrucoes(contador4)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference load extension from the byte/half arithmetic rules.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off);
    int unsigned b, h;
    b = (w >> (8 * int'(off))) & 32'hFF;
    h = (w >> (16 * int'(off[1]))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  // Drive one cycle; if the instruction will be captured, push its expected write after the edge.
  task automatic step(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                      input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4,
                      input logic [2:0] f3, input logic [1:0] off,
                      input logic st, input logic fl, input logic rs);
    esperado_t e;
    bit        cap;
    valido_mem = v; reg_write_mem = rw; endereco_destino_mem = rd; sel_resultado_mem = sel;
    resultado_ula_mem = alu; dado_memoria_mem = mem; pc_mais4_mem = pc4;
    funct3_mem = f3; endereco_byte_mem = off; stall = st; flush = fl; reset = rs;
    cap    = !rs && !fl && !st && v;
    e.we   = rw && (rd != 5'd0);
    e.rd   = rd;
    e.data = (sel == 2'b01) ? ref_load(mem, f3, off) : (sel == 2'b10) ? pc4 : alu;
    @(posedge clk);
    if (cap) exp_q.push_back(e);
    #1;
  endtask

  task automatic rand_step(input logic st, input logic fl, input logic rs);
    step(1'($urandom), 1'($urandom), 5'($urandom), 2'($urandom), $urandom, $urandom, $urandom,
         3'($urandom), 2'($urandom), st, fl, rs);
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 32'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare WB outputs against the queue front, then retire/drop per this edge's controls.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() != 0) begin
        chk("valido_wb", 32'(valido_wb), 32'd1);
        chk("habilita", 32'(habilita_escrita), 32'(exp_q[0].we));
        chk("endereco", 32'(endereco_destino), 32'(exp_q[0].rd));
        chk("dado", dado_escrita, exp_q[0].data);
        chk("dado_w4", dado_escrita4, exp_q[0].data);
      end else begin
        chk("valido_wb_bolha", 32'(valido_wb), 32'd0);
        chk("habilita_bolha", 32'(habilita_escrita), 32'd0);
      end
      chk("contador", contador_instrucoes, exp_cnt);
      chk("contador4", 32'(contador4), exp_cnt % 16);
      chk("w4_iguais", {habilita_escrita4, valido_wb4, endereco_destino4},
          {exp_q.size() != 0 && exp_q[0].we, exp_q.size() != 0,
           exp_q.size() != 0 ? exp_q[0].rd : endereco_destino4});
      if (reset) begin
        exp_q.delete();
        exp_cnt = 0;
      end else if (exp_q.size() != 0 && (!stall || flush)) begin
        void'(exp_q.pop_front());
        if (!stall) exp_cnt++;
      end
    end
  end

  initial begin
    // Reset with random inputs.
    rand_step(1'b0, 1'b0, 1'b1);
    mon_en = 1'b1;
    rand_step(1'b1, 1'b1, 1'b1);
    chk("reset_rd", 32'(endereco_destino), 32'd0);
    chk("reset_dado", dado_escrita, 32'd0);
    chk("reset_cnt", contador_instrucoes, 32'd0);

    // ALU write to x1.
    step(1'b1, 1'b1, 5'd1, 2'b00, 32'hA5A5_A5A5, 32'd0, 32'd0, 3'd2, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("alu_we", 32'(habilita_escrita), 32'd1);
    chk("alu_dado", dado_escrita, 32'hA5A5_A5A5);
    idle_step();
    chk("alu_cnt", contador_instrucoes, 32'd1);

    // Load extension table.
    begin
      logic [2:0]  f3s [8] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
      logic [1:0]  offs[8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd0, 2'd1};
      logic [31:0] exps[8] = '{32'h0000_005A, 32'h0000_007F, 32'hFFFF_FFF1, 32'hFFFF_FF80,
                               32'h0000_0080, 32'hFFFF_80F1, 32'h0000_7F5A, 32'h80F1_7F5A};
      for (int i = 0; i < 8; i++) begin
        step(1'b1, 1'b1, 5'd7, 2'b01, 32'd0, 32'h80F1_7F5A, 32'd0, f3s[i], offs[i],
             1'b0, 1'b0, 1'b0);
        chk("carga", dado_escrita, exps[i]);
      end
    end

    // JAL to x0 then x5.
    step(1'b1, 1'b1, 5'd0, 2'b10, 32'd0, 32'd0, 32'h104, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("jal_x0_we", 32'(habilita_escrita), 32'd0);
    step(1'b1, 1'b1, 5'd5, 2'b10, 32'd0, 32'd0, 32'h104, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("jal_x5_dado", dado_escrita, 32'h104);

    // Stall three cycles holding x2, then release.
    step(1'b1, 1'b1, 5'd2, 2'b00, 32'h5A5A_5A5A, 32'd0, 32'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) rand_step(1'b1, 1'b0, 1'b0);
    idle_step();

    // Flush and stall together over a valid instruction.
    step(1'b1, 1'b1, 5'd9, 2'b00, 32'h1234_5678, 32'd0, 32'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    rand_step(1'b1, 1'b1, 1'b0);
    chk("flush_valido", 32'(valido_wb), 32'd0);
    chk("flush_we", 32'(habilita_escrita), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++)
      rand_step(($urandom % 5) == 0, ($urandom % 10) == 0, ($urandom % 40) == 0);

    // Counter wrap: 17 retirements on a 4-bit counter.
    rand_step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++)
      step(1'b1, 1'b0, 5'($urandom), 2'd0, $urandom, 32'd0, 32'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    idle_step();
    chk("wrap4", 32'(contador4), 32'd1);

    // Reset during a stall drops the pending write.
    step(1'b1, 1'b1, 5'd3, 2'b00, 32'hCAFE_F00D, 32'd0, 32'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    rand_step(1'b1, 1'b0, 1'b0);
    rand_step(1'b1, 1'b0, 1'b1);
    chk("rst_stall_we", 32'(habilita_escrita), 32'd0);
    chk("rst_stall_cnt", contador_instrucoes, 32'd0);
    idle_step();
    idle_step();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/estagio_wb.md
# estagio_wb

Write-back stage of the five-stage RV32I pipeline. It holds the MEM/WB pipeline register, aligns and extends load data, and selects the result. It drives the write port of `register_file` (`habilita_escrita`, `endereco_destino`, `dado_escrita`), so it is the writer side of the interface that the ID stage reads. It also exposes the same write for forwarding and keeps a retired-instruction counter.

## Interface
Parameters:
- `LARGURA_CONTADOR`, default 32: width of the retired-instruction counter.

Ports:
- `clk` — in, 1: single clock; every register updates on the rising edge.
- `reset` — in, 1: synchronous, active-high.
- `stall` — in, 1: hold the MEM/WB register.
- `flush` — in, 1: load a bubble into the MEM/WB register.
- `valido_mem` — in, 1: the MEM-stage instruction is valid.
- `reg_write_mem` — in, 1: the instruction writes rd.
- `endereco_destino_mem` — in, 5: rd.
- `sel_resultado_mem` — in, 2: result select.
  - 00 = ALU
  - 01 = memory
  - 10 = PC+4
  - 11 = ALU
- `resultado_ula_mem` — in, 32: ALU result.
- `dado_memoria_mem` — in, 32: raw aligned data-memory word.
- `pc_mais4_mem` — in, 32: PC+4 (JAL/JALR link value).
- `funct3_mem` — in, 3: load type.
- `endereco_byte_mem` — in, 2: address bits [1:0].
- `habilita_escrita` — out, 1: register-file write enable.
- `endereco_destino` — out, 5: register-file write address.
- `dado_escrita` — out, 32: register-file write data.
- `valido_wb` — out, 1: the WB register holds a valid instruction.
- `contador_instrucoes` — out, `LARGURA_CONTADOR`: number of retired instructions.

## Operation
- **MEM/WB register.** It holds every `*_mem` input except `valido_mem`, which is stored as `valido_q`.
- **Update priority on each edge:**
  - `reset`: clear `valido_q` and all fields to 0, and clear the counter to 0.
  - otherwise `flush`: `valido_q` = 0; the other fields are don't-care.
  - otherwise `stall`: hold every field.
  - otherwise: capture all inputs.
- **Write enable.** `habilita_escrita = valido_q & reg_write_q & (rd_q != 0)`. A write to x0 is never issued.
- **Address output.** `endereco_destino = rd_q` at all times.
- **Load extension** (combinational, from the registered fields):
  - LB (000): sign-extend byte `endereco_byte_q`; byte k = bits [8k+7:8k].
  - LBU (100): same byte, zero-extended.
  - LH (001): sign-extend half `endereco_byte_q[1]`; half 0 = [15:0], half 1 = [31:16]; `endereco_byte_q[0]` is ignored.
  - LHU (101): same half, zero-extended.
  - LW (010) and any other funct3: the whole word; offset ignored.
- **Result select.** `dado_escrita` is the ALU result, the extended load, or PC+4, chosen by `sel_q`. It is driven even when `habilita_escrita` = 0.
- **Counter.** Increments by 1 on each edge where `valido_q` = 1, `stall` = 0 and `reset` = 0. It counts instructions leaving WB, whether or not they write. It wraps modulo 2^`LARGURA_CONTADOR` with no saturation.

## Timing
- **Reset values.** All outputs read 0 in the cycle after `reset`:
  - `habilita_escrita` = 0, `endereco_destino` = 0, `dado_escrita` = 0 (ALU select, result 0), `valido_wb` = 0, `contador_instrucoes` = 0.
- **Latency.** An instruction captured at edge N has its outputs valid combinationally during cycle N..N+1. `register_file` commits it at edge N+1; ID reads the new value in cycle N+1 because the register file write-through is not part of this block.
- **Stall.** While `stall` is held, the outputs repeat the same write every cycle. This is idempotent, and the counter does not advance.
- **Flush and stall together.** Flush wins: a bubble is loaded.
- **Reset mid-operation.** Reset overrides stall and flush. An in-flight instruction is discarded without writing or being counted.
- **Bubbles.** A valid instruction with `reg_write` = 0 (store or branch) produces no write but is counted.

## Structure
- **Shared package `pacote_riscv`:**
  - `SEL_ULA` = 2'b00, `SEL_MEM` = 2'b01, `SEL_PC4` = 2'b10
  - `F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`
  - `REG_ZERO` = 5'd0
- **Sub-module `extensor_carga`.** Purely combinational: (word, funct3, offset) -> 32-bit extended value. It is reused by the MEM-stage forwarding path.
- **Top level.** Contains the MEM/WB register, the result mux, the write-enable logic and the counter.

## Test plan
- **Reset.** Assert `reset` for 2 cycles with random inputs -> every output is 0; `contador_instrucoes` = 0.
- **ALU write.** `rd`=1, ALU result 0xA5A5A5A5, `sel`=00, `valido`=1, `reg_write`=1 -> one cycle later `habilita_escrita`=1, `endereco_destino`=1, `dado_escrita`=0xA5A5A5A5. A read of x1 in the following cycle returns 0xA5A5A5A5; the counter reads 1.
- **Load extension.** Memory word 0x80F17F5A, with LB and `endereco_byte`=0..3 -> 0x0000005A, 0x0000007F, 0xFFFFFFF1, 0xFFFFFF80. LBU at offset 3 -> 0x00000080; LH at offset 2 -> 0xFFFF80F1; LHU at offset 0 -> 0x00007F5A; LW -> 0x80F17F5A.
- **Link and x0.** JAL with `rd`=0 and PC+4 = 0x00000104 -> `habilita_escrita`=0, x0 still reads 0, counter increments. The same instruction with `rd`=5 -> x5 = 0x00000104.
- **Stall and flush.**
  - Stall 3 cycles holding `rd`=2, data 0x5A5A5A5A -> the write repeats and the counter advances by exactly 1 after stall is released.
  - Flush and stall together -> `valido_wb`=0 and no write.
- **Wrap and reset mid-stall.**
  - With `LARGURA_CONTADOR`=4, retire 17 instructions -> counter reads 1.
  - Assert reset during a stall -> the pending write is dropped.
